// File: rtl/tensor_core_result_drain.sv
// tensor_core_result_drain
// Walks the tensor core register file dual-read port over addresses
// 0..NUM_PAIRS-1. Each pair is captured in its own fetch cycle and then
// serialised, one element per transfer, onto a valid/ready stream. Flat
// element index 2*p is slot 0 of address p, and 2*p+1 is slot 1.
// Every output is driven straight from a flop. The next-cycle value of each
// output is decoded from the next state, so no output has combinational
// logic between the flops and the port.

module tensor_core_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PAIRS  = 9
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic                       start_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [3:0]                 dual_read_register_address_out,
    input  logic [1:0][DATA_WIDTH-1:0] dual_read_data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       last_out,
    output logic [4:0]                 element_index_out
);

    localparam logic [3:0] LAST_PAIR = 4'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT0 = 3'd2,
        ST_EMIT1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [3:0]                   pair_idx_r;
    logic [3:0]                   pair_next_s;
    logic [1:0][DATA_WIDTH-1:0]   buf_r;
    logic [1:0][DATA_WIDTH-1:0]   buf_next_s;

    logic                         valid_next_s;
    logic                         last_next_s;
    logic                         done_next_s;
    logic                         busy_next_s;
    logic [DATA_WIDTH-1:0]        data_next_s;
    logic [4:0]                   index_next_s;

    logic                         valid_r;
    logic                         last_r;
    logic                         done_r;
    logic                         busy_r;
    logic [DATA_WIDTH-1:0]        data_r;
    logic [4:0]                   index_r;

    // Next-state, pair counter and capture buffer decode for the drain sequence.
    always_comb begin
        state_next_s = state_r;
        pair_next_s  = pair_idx_r;
        buf_next_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    pair_next_s  = 4'd0;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // The register file read is combinational, so the pair
                // addressed by pair_idx_r is valid during this cycle.
                buf_next_s   = dual_read_data_in;
                state_next_s = ST_EMIT0;
            end
            ST_EMIT0: begin
                if (ready_in) begin
                    state_next_s = ST_EMIT1;
                end else begin
                    state_next_s = ST_EMIT0;
                end
            end
            ST_EMIT1: begin
                if (ready_in) begin
                    if (pair_idx_r == LAST_PAIR) begin
                        state_next_s = ST_DONE;
                    end else begin
                        pair_next_s  = pair_idx_r + 4'd1;
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_EMIT1;
                end
            end
            ST_DONE: begin
                // start_in is deliberately not looked at here.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Decode the values the stream and status outputs take in the next state.
    always_comb begin
        valid_next_s = 1'b0;
        last_next_s  = 1'b0;
        data_next_s  = '0;
        index_next_s = 5'd0;
        done_next_s  = (state_next_s == ST_DONE);
        busy_next_s  = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_EMIT0: begin
                valid_next_s = 1'b1;
                data_next_s  = buf_next_s[0];
                index_next_s = {pair_next_s, 1'b0};
            end
            ST_EMIT1: begin
                valid_next_s = 1'b1;
                data_next_s  = buf_next_s[1];
                index_next_s = {pair_next_s, 1'b1};
                last_next_s  = (pair_next_s == LAST_PAIR);
            end
            default: begin
                valid_next_s = 1'b0;
                last_next_s  = 1'b0;
                data_next_s  = '0;
                index_next_s = 5'd0;
            end
        endcase
    end

    // Register the state, the pair counter and the capture buffers. Reset has the highest priority.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r    <= ST_IDLE;
            pair_idx_r <= 4'd0;
            buf_r      <= '0;
        end else begin
            state_r    <= state_next_s;
            pair_idx_r <= pair_next_s;
            buf_r      <= buf_next_s;
        end
    end

    // Register all stream and status outputs so they are glitch-free.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= '0;
            index_r <= 5'd0;
        end else begin
            valid_r <= valid_next_s;
            last_r  <= last_next_s;
            done_r  <= done_next_s;
            busy_r  <= busy_next_s;
            data_r  <= data_next_s;
            index_r <= index_next_s;
        end
    end

    assign dual_read_register_address_out = pair_idx_r;
    assign data_out                       = data_r;
    assign valid_out                      = valid_r;
    assign last_out                       = last_r;
    assign element_index_out              = index_r;
    assign done_out                       = done_r;
    assign busy_out                       = busy_r;

endmodule

// File: tb/tb_tensor_core_result_drain.sv
// Bench for tensor_core_result_drain. The bench models a register file of
// 9 x 2 elements and keeps it in an array. For each drain it builds the
// expected element queue from that array and checks the stream against it.

module tb_tensor_core_result_drain;

    logic            clock_in;
    logic            reset_in;
    logic            start_in;
    logic            busy_out;
    logic            done_out;
    logic [3:0]      addr;
    logic [1:0][7:0] rd_data;
    logic [7:0]      data_out;
    logic            valid_out;
    logic            ready_in;
    logic            last_out;
    logic [4:0]      element_index_out;

    logic [7:0] regs [0:8][0:1];
    int pass_cnt = 0;
    int chk_cnt  = 0;

    tensor_core_result_drain #(.DATA_WIDTH(8), .NUM_PAIRS(9)) dut (
        .clock_in                       (clock_in),
        .reset_in                       (reset_in),
        .start_in                       (start_in),
        .busy_out                       (busy_out),
        .done_out                       (done_out),
        .dual_read_register_address_out (addr),
        .dual_read_data_in              (rd_data),
        .data_out                       (data_out),
        .valid_out                      (valid_out),
        .ready_in                       (ready_in),
        .last_out                       (last_out),
        .element_index_out              (element_index_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Combinational dual-read port of the modelled register file.
    always_comb begin
        rd_data = '0;
        if (addr < 4'd9) begin
            rd_data[0] = regs[addr][0];
            rd_data[1] = regs[addr][1];
        end
    end

    task automatic tick();
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    task automatic load_regs(input int kind);
        logic [7:0] pat [0:2];
        pat[0] = 8'h80; pat[1] = 8'h7F; pat[2] = 8'hFF;
        for (int k = 0; k < 18; k++) begin
            case (kind)
                0:       regs[k/2][k%2] = 8'(k + 1);
                1:       regs[k/2][k%2] = pat[k%3];
                default: regs[k/2][k%2] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Starts one drain from IDLE and checks the stream cycle by cycle.
    // mode: 0 ready high, 1 ready toggles, 2 random ready, 3 ready low
    // for the first 50 cycles of element 0. abort_after > 0 applies
    // reset right after that many transfers.
    task automatic run_drain(input int mode, input int abort_after, input bit poke_start, output int xfers);
        logic [7:0] expq [$];
        int  cyc;
        int  hold_cnt;
        int  exp_addr;
        bit  done_seen;
        bit  stalled;
        bit  xfer_now;
        for (int k = 0; k < 18; k++) expq.push_back(regs[k/2][k%2]);
        xfers = 0; stalled = 1'b0; done_seen = 1'b0; hold_cnt = 0;
        start_in = 1'b1; ready_in = 1'b0;
        tick();
        start_in = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 400) begin
            chk_cnt++;
            if (busy_out !== 1'b1) $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy_out);
            else pass_cnt++;
            exp_addr = (xfers / 2 > 8) ? 8 : xfers / 2;
            chk_cnt++;
            if (addr !== 4'(exp_addr)) $display("FAIL addr cyc=%0d got=%0d exp=%0d", cyc, addr, exp_addr);
            else pass_cnt++;
            if (stalled) begin
                chk_cnt++;
                if (valid_out !== 1'b1) $display("FAIL valid_held cyc=%0d got=%b exp=1", cyc, valid_out);
                else pass_cnt++;
            end
            if (valid_out === 1'b1) begin
                chk_cnt++;
                if (xfers >= 18) $display("FAIL extra_element cyc=%0d got=%0d exp<18", cyc, xfers);
                else if (data_out !== expq[xfers])
                    $display("FAIL data idx=%0d got=%0d exp=%0d", xfers, $signed(data_out), $signed(expq[xfers]));
                else pass_cnt++;
                chk_cnt++;
                if (element_index_out !== 5'(xfers))
                    $display("FAIL index cyc=%0d got=%0d exp=%0d", cyc, element_index_out, xfers);
                else pass_cnt++;
                chk_cnt++;
                if (last_out !== (xfers == 17)) $display("FAIL last idx=%0d got=%b exp=%b", xfers, last_out, xfers == 17);
                else pass_cnt++;
            end else begin
                chk_cnt++;
                if (data_out !== 8'd0 || element_index_out !== 5'd0 || last_out !== 1'b0)
                    $display("FAIL idle_stream cyc=%0d got=%0d/%0d/%b exp=0/0/0", cyc, data_out, element_index_out, last_out);
                else pass_cnt++;
            end
            if (done_out === 1'b1) begin
                done_seen = 1'b1;
                chk_cnt++;
                if (xfers != 18) $display("FAIL done_count got=%0d exp=18", xfers);
                else pass_cnt++;
                if (mode == 0) begin
                    chk_cnt++;
                    if (cyc != 28) $display("FAIL done_latency got=%0d exp=28", cyc);
                    else pass_cnt++;
                end
            end
            case (mode)
                0: ready_in = 1'b1;
                1: ready_in = cyc[0];
                2: ready_in = 1'($urandom_range(0, 1));
                default: begin
                    if (xfers == 0 && valid_out === 1'b1 && hold_cnt < 50) begin
                        ready_in = 1'b0;
                        hold_cnt++;
                    end else begin
                        ready_in = 1'b1;
                    end
                end
            endcase
            if (poke_start) start_in = (done_out === 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
            else start_in = 1'b0;
            stalled  = (valid_out === 1'b1) && !ready_in;
            xfer_now = (valid_out === 1'b1) && ready_in;
            tick();
            start_in = 1'b0;
            cyc++;
            if (xfer_now) xfers++;
            if (abort_after > 0 && xfer_now && xfers == abort_after) begin
                reset_in = 1'b1;
                tick();
                reset_in = 1'b0;
                chk_cnt++;
                if (valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || addr !== 4'd0)
                    $display("FAIL abort_state got v=%b b=%b d=%b a=%0d exp=0/0/0/0", valid_out, busy_out, done_out, addr);
                else pass_cnt++;
                return;
            end
        end
        ready_in = 1'b0;
        chk_cnt++;
        if (!done_seen) $display("FAIL drain_timeout got=no_done exp=done within %0d cycles", cyc);
        else pass_cnt++;
        chk_cnt++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || valid_out !== 1'b0)
            $display("FAIL after_done got b=%b d=%b v=%b exp=0/0/0", busy_out, done_out, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
        tick(); tick();
        reset_in = 1'b0;
        chk_cnt++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || last_out !== 1'b0 ||
            data_out !== 8'd0 || element_index_out !== 5'd0 || addr !== 4'd0)
            $display("FAIL reset_state got v=%b b=%b d=%b l=%b data=%0d idx=%0d a=%0d exp=all 0",
                     valid_out, busy_out, done_out, last_out, data_out, element_index_out, addr);
        else pass_cnt++;
    endtask

    task automatic test_full_ready();
        int n;
        load_regs(0);
        run_drain(0, 0, 1'b0, n);
    endtask

    task automatic test_toggle_ready();
        int n;
        load_regs(0);
        run_drain(1, 0, 1'b0, n);
    endtask

    task automatic test_signed_pattern();
        int n;
        load_regs(1);
        run_drain(0, 0, 1'b0, n);
    endtask

    task automatic test_reset_mid_drain();
        int n;
        load_regs(0);
        run_drain(0, 7, 1'b0, n);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (done_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL no_done_after_abort got d=%b b=%b exp=0/0", done_out, busy_out);
            else pass_cnt++;
            tick();
        end
        run_drain(0, 0, 1'b0, n);
    endtask

    task automatic test_back_to_back();
        int n;
        load_regs(2);
        run_drain(2, 0, 1'b1, n);
        run_drain(0, 0, 1'b0, n);
    endtask

    task automatic test_long_stall();
        int n;
        load_regs(0);
        run_drain(3, 0, 1'b0, n);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            load_regs(2);
            run_drain(2, 0, 1'b0, n);
        end
    endtask

    initial begin
        reset_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
        for (int k = 0; k < 18; k++) regs[k/2][k%2] = 8'd0;
        @(negedge clock_in);
        test_reset();
        test_full_ready();
        test_toggle_ready();
        test_signed_pattern();
        test_reset_mid_drain();
        test_back_to_back();
        test_long_stall();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
